// File: rtl/csa_accum_ctrl.sv
// rtl/csa_accum_ctrl.sv - carry-save operand accumulator with a one-cycle resolve stage
// Operands are folded into a redundant (S, C) pair, and the carry-propagate add runs only once per batch.
module csa_accum_ctrl #(
   parameter int N_OPS = 9,
   parameter int W     = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic           abort,
   input  logic           in_valid,
   input  logic [W-1:0]   in_data,
   output logic           in_ready,
   output logic           busy,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W+3:0]   out_sum,
   output logic           out_cout
);

   localparam int CNT_W = $clog2(N_OPS + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCUM   = 2'd1,
      RESOLVE = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t             state;
   logic [W+4:0]       s_q;
   logic [W+4:0]       c_q;
   logic [CNT_W-1:0]   cnt;
   logic [W+4:0]       x_ext;
   logic [W+4:0]       maj;
   logic               last_op;

   assign x_ext   = {5'b0, in_data};
   assign maj     = (s_q & c_q) | (s_q & x_ext) | (c_q & x_ext);
   assign last_op = (cnt == CNT_W'(N_OPS - 1));

   // in_ready/busy/out_valid are flops updated together with state so they never glitch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         s_q       <= '0;
         c_q       <= '0;
         cnt       <= '0;
         out_sum   <= '0;
         out_cout  <= 1'b0;
         in_ready  <= 1'b0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  s_q      <= '0;
                  c_q      <= '0;
                  cnt      <= '0;
                  state    <= ACCUM;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            ACCUM: begin
               if (abort) begin
                  state    <= IDLE;
                  in_ready <= 1'b0;
                  busy     <= 1'b0;
               end else if (in_valid) begin
                  s_q <= s_q ^ c_q ^ x_ext;
                  // Shift drops the top carry; the W+5 bit pair already covers 16 full-width operands.
                  c_q <= maj << 1;
                  cnt <= cnt + CNT_W'(1);
                  if (last_op) begin
                     state    <= RESOLVE;
                     in_ready <= 1'b0;
                  end
               end
            end
            RESOLVE: begin
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  {out_cout, out_sum} <= s_q + c_q;
                  state               <= DONE;
                  out_valid           <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b0;
               busy      <= 1'b0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
